// File: rtl/core_pkg.sv
// Shared pipeline hazard types: controller FSM states and forwarding-mux selects.
// Pure declarations, no logic.
package core_pkg;

    localparam int REG_ADDR_W_DFLT = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register; MEM result beats WB data.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of the current pipeline contents.
module fwd_select
    import core_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, dmem freeze.
// Latency: control outputs combinational from inputs and the registered FSM state.
// Backpressure: dmem wait freezes every stage; optional counters behind HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
    import core_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DFLT,
    parameter int FLUSH_DEPTH = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_bubble,
    output logic                  mem_timeout,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    hz_state_e        state_q, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       sel_a, sel_b;
    logic             mem_wait, load_use, lu_armed;

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src(ex_rs1), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_a)
    );

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src(ex_rs2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(sel_b)
    );

    // Outputs fall back to their idle values while reset is held, regardless of inputs.
    assign forward_a = rstn ? sel_a : FWD_RF;
    assign forward_b = rstn ? sel_b : FWD_RF;

    assign mem_wait = dmem_req && !dmem_ready;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
    // The cycle after a flush or a load stall never starts a new load stall.
    assign lu_armed = (state_q == RUN) || (state_q == MEM_WAIT);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        state_nxt    = RUN;
        if (!rstn) begin
            state_nxt = RUN;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = (FLUSH_DEPTH >= 2);
            exmem_flush = (FLUSH_DEPTH == 3);
            state_nxt   = FLUSH;
        end else if (mem_wait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            state_nxt    = MEM_WAIT;
        end else if (load_use && lu_armed) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_nxt  = LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (mem_wait && !branch_taken) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt == CNT_MAX) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (((state_q == LOAD_STALL) || (state_q == MEM_WAIT)) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with a queue-based scoreboard.
// Expected vector: {fwd_a, fwd_b, pc/ifid/idex/exmem_en, ifid/idex/exmem_flush+bubble, timeout, state}.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
    logic       branch_taken, dmem_req, dmem_ready;
    logic [1:0] forward_a, forward_b, state_o;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_DEPTH(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [14:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [3:0] en, input logic [3:0] fl,
                                       input logic to, input logic [1:0] st);
        return {fa, fb, en, fl, to, st};
    endfunction

    task automatic idle_in();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [14:0] exp);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a full control word; compare it mid-cycle.
    initial begin
        logic [14:0] act;
        sb_entry_t   e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {forward_a, forward_b, pc_en, ifid_en, idex_en, exmem_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_timeout, state_o};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        int guard;
        idle_in();

        // Reset holds idle outputs even with a hazard and a forwarding match on the inputs.
        next_cycle();
        dmem_req = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5; ex_rs1 = 5'd5;
        push("reset_idle", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        rstn = 1'b1; idle_in();
        push("post_reset", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs1 = 5'd5;
        push("fwd_mem_prio", mk(2'b10, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        mem_reg_write = 1'b0;
        push("fwd_wb", mk(2'b01, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1; ex_rs1 = 5'd0;
        push("fwd_x0", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        mem_rd = 5'd7; wb_rd = 5'd9; ex_rs1 = 5'd9; ex_rs2 = 5'd7;
        push("fwd_a_wb_b_mem", mk(2'b01, 2'b10, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        idle_in();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        push("load_use_hit", mk(2'b00, 2'b00, 4'b0011, 4'b0100, 1'b0, 2'd0));

        next_cycle();
        push("load_stall_guard", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd1));

        next_cycle();
        idle_in();
        push("load_stall_exit", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs2 = 5'd3;
        push("no_use_no_stall", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        push("load_x0_no_stall", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        next_cycle();
        ex_rd = 5'd3; id_rs1 = 5'd3; branch_taken = 1'b1;
        push("branch_beats_lu", mk(2'b00, 2'b00, 4'b1111, 4'b1110, 1'b0, 2'd0));

        next_cycle();
        branch_taken = 1'b0;
        push("flush_state", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd3));

        next_cycle();
        idle_in();
        push("flush_exit", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        for (int i = 0; i < 4; i++) begin
            next_cycle();
            dmem_req = 1'b1; dmem_ready = 1'b0;
            push($sformatf("mem_wait_%0d", i),
                 mk(2'b00, 2'b00, 4'b0000, 4'b0001, 1'b0, (i == 0) ? 2'd0 : 2'd2));
        end
        next_cycle();
        dmem_ready = 1'b1;
        push("mem_ready", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd2));
        next_cycle();
        idle_in();
        push("mem_wait_exit", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            dmem_req = 1'b1; dmem_ready = 1'b0;
            push($sformatf("timeout_wait_%0d", i),
                 mk(2'b00, 2'b00, 4'b0000, 4'b0001, 1'b0, (i == 0) ? 2'd0 : 2'd2));
        end
        next_cycle();
        dmem_ready = 1'b1;
        push("timeout_set", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b1, 2'd2));
        next_cycle();
        idle_in();
        push("timeout_sticky", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b1, 2'd0));

        // Mem wait outranks load-use; the load-use is picked up on the ready cycle.
        next_cycle();
        dmem_req = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        push("wait_beats_lu", mk(2'b00, 2'b00, 4'b0000, 4'b0001, 1'b1, 2'd0));
        next_cycle();
        dmem_ready = 1'b1;
        push("lu_on_wait_exit", mk(2'b00, 2'b00, 4'b0011, 4'b0100, 1'b1, 2'd2));
        next_cycle();
        idle_in();
        push("stall_after_wait", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b1, 2'd1));

        next_cycle();
        dmem_req = 1'b1;
        push("rst_wait_0", mk(2'b00, 2'b00, 4'b0000, 4'b0001, 1'b1, 2'd0));
        next_cycle();
        push("rst_wait_1", mk(2'b00, 2'b00, 4'b0000, 4'b0001, 1'b1, 2'd2));
        next_cycle();
        rstn = 1'b0;
        push("async_reset", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));
        next_cycle();
        rstn = 1'b1; idle_in();
        push("reset_release", mk(2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 2'd0));

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central pipeline hazard controller for the 5-stage RV32I core: IF, ID, EX, MEM, WB.
- Combines EX operand forwarding, load-use stall, branch-taken flush and data-memory wait-state freeze in one block.
- Generalises the existing fixed 5-bit forwarding unit:
  - register address width is a parameter;
  - the flush depth is set by the stage where branches resolve;
  - it adds a registered control FSM with a memory-wait timeout.
- Drives the enable/flush inputs of all four pipeline registers and the PC.

Parameters:
REG_ADDR_W, 5, register index width (x0 is always index 0)
FLUSH_DEPTH, 3, number of younger pipeline registers cleared on branch taken (3 = IF/ID, ID/EX, EX/MEM; legal 1..3)
MEM_TIMEOUT, 15, max consecutive dmem wait cycles before mem_timeout is raised

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads that source
ex_rs1, ex_rs2  in  REG_ADDR_W  sources of the instruction in EX
ex_rd  in  REG_ADDR_W  destination in EX
ex_mem_read  in  1  EX instruction is a load
mem_rd, wb_rd  in  REG_ADDR_W  destinations in MEM / WB
mem_reg_write, wb_reg_write  in  1  register write enables in MEM / WB
branch_taken  in  1  branch resolved taken in MEM
dmem_req  in  1  MEM stage access active
dmem_ready  in  1  data memory completes this cycle
forward_a, forward_b  out  2  00 regfile, 01 WB data, 10 MEM result
pc_en, ifid_en, idex_en, exmem_en  out  1  register enables
ifid_flush, idex_flush, exmem_flush, memwb_bubble  out  1  synchronous clears / bubble insert
mem_timeout  out  1  sticky wait-timeout error
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async, rstn=0):
  - state=RUN, wait_cnt=0, mem_timeout=0, perf counters=0.
  - Enables read 1, flushes read 0, forward=00.
- Forwarding (combinational):
  - forward_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Else 00. forward_b uses the same rules on ex_rs2.
  - MEM has priority over WB.
- Priority of control events: branch_taken > mem wait > load-use.
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.
- Branch_taken in any state:
  - Flush outputs are asserted the same cycle: ifid_flush, plus idex_flush if FLUSH_DEPTH>=2, plus exmem_flush if FLUSH_DEPTH==3.
  - pc_en=1; next state FLUSH.
  - FLUSH lasts 1 cycle with no flushes and load-use detection masked, then returns to RUN.
- Mem wait (dmem_req && !dmem_ready, no branch_taken):
  - pc_en, ifid_en, idex_en and exmem_en are driven to 0; memwb_bubble=1.
  - Next state MEM_WAIT; wait_cnt increments and saturates at MEM_TIMEOUT.
  - mem_timeout is set when wait_cnt==MEM_TIMEOUT and stays set until reset.
  - Leave to RUN on dmem_ready, which clears wait_cnt.
- Load-use hazard:
  - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1; next state LOAD_STALL.
  - LOAD_STALL lasts exactly 1 cycle and is never re-entered back-to-back. The bubble clears the condition; the FSM guards it anyway.
- Mem wait during LOAD_STALL: MEM_WAIT takes priority. The load-use condition is re-evaluated on exit.
- Freezes and flushes are held for the full cycle. No output depends on clk edges other than via the state registers.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit saturating outputs stall_cycles (LOAD_STALL plus MEM_WAIT cycles) and flush_count (branch_taken events).
  - Both reset to 0.
  - They hold at 32'hFFFF_FFFF on saturation.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - hz_state_e enum (RUN, LOAD_STALL, MEM_WAIT, FLUSH);
  - fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - REG_ADDR_W default constant.
- One natural sub-module, fwd_select: pure combinational, instantiated twice, for operand A and operand B.

Test Plan:
- Forwarding:
  - mem_rd=5, wb_rd=5, both writing, ex_rs1=5 -> forward_a=10.
  - mem_reg_write=0 -> forward_a=01.
  - rd=0 -> 00.
- Load-use:
  - ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, state_o=1.
  - Then RUN with enables=1.
- Branch:
  - branch_taken=1 with FLUSH_DEPTH=3 -> ifid/idex/exmem_flush=1 same cycle, state_o=3 next cycle, RUN after.
  - Simultaneous load-use is ignored.
- Mem wait:
  - dmem_req=1, dmem_ready=0 for 4 cycles -> all enables 0 and memwb_bubble=1 for 4 cycles.
  - Ready on cycle 5 -> RUN, wait_cnt=0.
- Timeout: hold not-ready 16 cycles with MEM_TIMEOUT=15 -> mem_timeout=1, still 1 after ready.
- Reset mid-MEM_WAIT: drop rstn -> state_o=0, mem_timeout=0 and enables=1 immediately (async).
